// File: rtl/div_iter.sv
// div_iter: multi-cycle iterative radix-2 restoring divider for MIPS DIV/DIVU
// in the execute stage. It raises a combinational stall to the hazard unit
// while a division is in flight. Quotient (LO) and remainder (HI) are
// presented with div_valid in the cycle the stall releases.
//
// Ports:
//   clk            pipeline clock
//   resetn         asynchronous active-low reset
//   div_start      E stage holds a valid DIV/DIVU (held while frozen)
//   div_signed     1 = DIV (two's complement), 0 = DIVU
//   div_cancel     E-stage exception flush, aborts any operation
//   dividend       rs operand, sampled on accept
//   divisor        rt operand, sampled on accept
//   div_stall      pipeline freeze request
//   div_valid      result valid this cycle
//   div_quotient   quotient (to LO), held until the next result
//   div_remainder  remainder (to HI), held until the next result
//
// Optional build macro:
//   DIV_EARLY_OUT_EN  when defined, a non-zero divisor whose magnitude
//                     exceeds the dividend's skips the iterations and
//                     completes in one cycle (q = 0, r = dividend).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for div_start; stall is raised in the accept cycle
// BUSY  | one shift-subtract step per cycle, DATA_WIDTH cycles in all
// DONE  | sign-fixed results on the outputs, div_valid high one cycle

module div_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic                  div_cancel,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  div_stall,
    output logic                  div_valid,
    output logic [DATA_WIDTH-1:0] div_quotient,
    output logic [DATA_WIDTH-1:0] div_remainder
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PR_W  = 2 * DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Partial remainder: upper DATA_WIDTH+1 bits hold the running
    // remainder, lower DATA_WIDTH bits shift the dividend out and the
    // quotient bits in.
    logic [PR_W-1:0]       pr_q, pr_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    // Raw dividend kept for the divide-by-zero remainder.
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  dz_q, dz_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;

    logic [DATA_WIDTH-1:0] mag_dvd;
    logic [DATA_WIDTH-1:0] mag_dvs;
    logic                  dvs_zero;
    logic [PR_W:0]         pr_shl;
    logic [DATA_WIDTH+1:0] trial;
    logic [PR_W-1:0]       pr_step;
    logic [DATA_WIDTH-1:0] q_raw;
    logic [DATA_WIDTH-1:0] r_raw;

    // Operand magnitudes and one restoring step.
    always_comb begin
        mag_dvd  = (div_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
        mag_dvs  = (div_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
        dvs_zero = (divisor == '0);

        // The top bit of pr_q is always zero (remainder < divisor), so the
        // shifted upper part fits in DATA_WIDTH+1 bits; one extra bit in the
        // trial subtraction carries the borrow.
        pr_shl  = {pr_q, 1'b0};
        trial   = pr_shl[PR_W:DATA_WIDTH] - {2'b00, dvs_q};
        pr_step = trial[DATA_WIDTH+1]
                ? pr_shl[PR_W-1:0]
                : {trial[DATA_WIDTH:0], pr_shl[DATA_WIDTH-1:1], 1'b1};
        q_raw   = pr_step[DATA_WIDTH-1:0];
        r_raw   = pr_step[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        if (div_cancel) begin
            // Flush wins in every state; results from an earlier division
            // stay on the outputs.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_start) begin
                        pr_d    = {{(DATA_WIDTH+1){1'b0}}, mag_dvd};
                        dvs_d   = mag_dvs;
                        dvd_d   = dividend;
                        qneg_d  = div_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                        rneg_d  = div_signed & dividend[DATA_WIDTH-1];
                        dz_d    = dvs_zero;
                        cnt_d   = '0;
                        state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
                        if (!dvs_zero && (mag_dvd < mag_dvs)) begin
                            quot_d  = '0;
                            rem_d   = dividend;
                            state_d = DONE;
                        end
`endif
                    end
                end

                BUSY: begin
                    pr_d  = pr_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        if (dz_q) begin
                            // Divide by zero: no sign fixup on either result.
                            quot_d = '1;
                            rem_d  = dvd_q;
                        end else begin
                            quot_d = qneg_q ? -q_raw : q_raw;
                            rem_d  = rneg_q ? -r_raw : r_raw;
                        end
                    end
                end

                DONE: begin
                    // Back to IDLE regardless of div_start: a start still
                    // high here belongs to the instruction just completed.
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Stall is gated by resetn so that a start held through reset does not
    // freeze the pipeline while the divider is being cleared.
    always_comb begin
        div_stall = resetn & ~div_cancel
                  & (((state_q == IDLE) & div_start) | (state_q == BUSY));
        div_valid = ~div_cancel & (state_q == DONE);
    end

    assign div_quotient  = quot_q;
    assign div_remainder = rem_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter. A table of divisions is
// applied one at a time; each accepted division pushes its expected
// quotient, remainder and completion cycle into a scoreboard queue that is
// popped whenever div_valid is seen. Hand-written sequences cover cancel and
// mid-operation reset. Build with DIV_EARLY_OUT_EN defined to exercise the
// early-completion latency.
module tb_div_iter;

    localparam int W   = 32;
    localparam int LAT = W + 1;
    localparam int NV  = 12;

    logic         clk;
    logic         resetn;
    logic         div_start;
    logic         div_signed;
    logic         div_cancel;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         div_stall;
    logic         div_valid;
    logic [W-1:0] div_quotient;
    logic [W-1:0] div_remainder;

    div_iter #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_cancel    (div_cancel),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_stall     (div_stall),
        .div_valid     (div_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           due;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[NV];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle: check the stall and serve the scoreboard.
    task automatic sample(input logic exp_stall, input string tag);
        exp_t e;
        @(negedge clk);
        chk({tag, "_stall"}, W'(div_stall), W'(exp_stall));
        if (div_valid) begin
            if (sb.size() == 0) begin
                chk({tag, "_spurious_valid"}, W'(div_valid), '0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_quotient"}, div_quotient, e.q);
                chk({tag, "_remainder"}, div_remainder, e.r);
                chk({tag, "_valid_cycle"}, W'(cyc_cnt), W'(e.due));
            end
        end
    endtask

    function automatic int exp_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic         early;
        ma    = (s && a[W-1]) ? -a : a;
        mb    = (s && b[W-1]) ? -b : b;
        early = (b != '0) && (ma < mb);
`ifdef DIV_EARLY_OUT_EN
        return early ? 1 : LAT;
`else
        return (early && 1'b0) ? 1 : LAT;
`endif
    endfunction

    // Runs from the accept cycle t0 to one cycle past the result.
    task automatic finish_op(input int t0, input int lat, input logic [W-1:0] q,
                             input logic [W-1:0] r, input string tag);
        while (cyc_cnt < t0 + lat) begin
            sample(1'b1, tag);
            next_cycle();
        end
        sample(1'b0, tag);
        next_cycle();
        div_start = 1'b0;
        chk({tag, "_pending"}, W'(sb.size()), '0);
        sb.delete();
        sample(1'b0, tag);
        chk({tag, "_valid_after"}, W'(div_valid), '0);
        chk({tag, "_q_hold"}, div_quotient, q);
        chk({tag, "_r_hold"}, div_remainder, r);
        next_cycle();
    endtask

    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r,
                            input int lat, input string tag);
        exp_t e;
        int   t0;
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        t0         = cyc_cnt;
        e.q        = q;
        e.r        = r;
        e.due      = t0 + lat;
        sb.push_back(e);
        finish_op(t0, lat, q, r, tag);
    endtask

    initial begin
        int           t0;
        exp_t         e;
        logic [W-1:0] last_q;
        logic [W-1:0] last_r;

        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_cancel = 1'b0;
        dividend   = '0;
        divisor    = '0;

        //          sgn   dividend       divisor        quotient       remainder
        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
        vecs[5]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
        vecs[6]  = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[7]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3};
        vecs[8]  = '{1'b0, 32'd30,        32'd10,        32'd3,         32'd0};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[10] = '{1'b1, 32'd0,         32'd5,         32'd0,         32'd0};
        vecs[11] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE};

        repeat (2) @(posedge clk);
        #1;
        sample(1'b0, "reset");
        chk("reset_valid", W'(div_valid), '0);
        chk("reset_quotient", div_quotient, '0);
        chk("reset_remainder", div_remainder, '0);
        #2 resetn = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                     exp_lat(vecs[i].sgn, vecs[i].a, vecs[i].b), $sformatf("vec%0d", i));
        end
        last_q = vecs[NV-1].q;
        last_r = vecs[NV-1].r;

        // Cancel in BUSY cycle 10, restart with DIVU 9/3 in cycle 12.
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        t0         = cyc_cnt;
        for (int i = 0; i < 10; i++) begin
            sample(1'b1, "cancel_busy");
            next_cycle();
        end
        div_cancel = 1'b1;
        sample(1'b0, "cancel_cycle");
        chk("cancel_valid", W'(div_valid), '0);
        next_cycle();
        div_cancel = 1'b0;
        div_start  = 1'b0;
        sample(1'b0, "cancel_idle");
        chk("cancel_q_hold", div_quotient, last_q);
        chk("cancel_r_hold", div_remainder, last_r);
        next_cycle();
        chk("cancel_restart_cycle", W'(cyc_cnt - t0), W'(12));
        start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, LAT, "after_cancel");

        // Reset in BUSY cycle 5 with div_start held; restart after release.
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, "rst_busy");
            next_cycle();
        end
        resetn = 1'b0;
        sample(1'b0, "rst_mid");
        chk("rst_mid_valid", W'(div_valid), '0);
        chk("rst_mid_quotient", div_quotient, '0);
        chk("rst_mid_remainder", div_remainder, '0);
        #2 resetn = 1'b1;
        t0    = cyc_cnt;
        e.q   = 32'd14;
        e.r   = 32'd2;
        e.due = t0 + LAT;
        sb.push_back(e);
        next_cycle();
        finish_op(t0, LAT, 32'd14, 32'd2, "rst_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
